// File: rtl/ci_initiator_if.sv
// Request/response stream plus Nios II custom-instruction bus for ci_initiator.
// The master modport is the initiator's view; slave is the view of whatever surrounds it.
interface ci_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        ci_clk_en;
    logic        ci_start;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic        ci_done;
    logic [31:0] ci_result;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, ci_done, ci_result,
        output req_ready, rsp_valid, rsp_data, rsp_timeout,
               ci_clk_en, ci_start, ci_dataa, ci_datab
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, ci_done, ci_result,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout,
               ci_clk_en, ci_start, ci_dataa, ci_datab
    );
endinterface

// File: rtl/ci_initiator.sv
// Master end of the Nios II multi-cycle custom-instruction handshake: one CI
// transaction per accepted operand pair, with a watchdog abort for dead slaves.
module ci_initiator #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           reset,
    ci_initiator_if.master bus,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_BUSY  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic             clk_en_r;
    logic             start_r;
    logic [31:0]      dataa_r;
    logic [31:0]      datab_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_data_r;
    logic             rsp_timeout_r;
    logic [CNT_W-1:0] cnt_r;

    logic             req_ready_s;
    logic             wd_hit_s;

    assign req_ready_s     = (state_r == S_IDLE) && clk_en_r;
    assign wd_hit_s        = (cnt_r == WD_LAST);
    assign busy            = (state_r != S_IDLE);

    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.ci_clk_en   = clk_en_r;
    assign bus.ci_start    = start_r;
    assign bus.ci_dataa    = dataa_r;
    assign bus.ci_datab    = datab_r;

    // Transaction FSM, watchdog counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= S_IDLE;
            clk_en_r      <= 1'b0;
            start_r       <= 1'b0;
            dataa_r       <= 32'h0000_0000;
            datab_r       <= 32'h0000_0000;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 32'h0000_0000;
            rsp_timeout_r <= 1'b0;
            cnt_r         <= '0;
        end else begin
            clk_en_r <= 1'b1;
            case (state_r)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_s) begin
                        dataa_r <= bus.req_a;
                        datab_r <= bus.req_b;
                        cnt_r   <= '0;
                        start_r <= 1'b1;
                        state_r <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // done is not looked at here; the slave has not seen start yet
                    start_r <= 1'b0;
                    state_r <= S_ARM;
                end
                S_ARM: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (!bus.ci_done) begin
                        state_r <= S_BUSY;
                    end else if (wd_hit_s) begin
                        rsp_data_r    <= 32'h0000_0000;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= S_RESP;
                    end
                end
                S_BUSY: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (bus.ci_done) begin
                        rsp_data_r    <= bus.ci_result;
                        rsp_timeout_r <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= S_RESP;
                    end else if (wd_hit_s) begin
                        rsp_data_r    <= 32'h0000_0000;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    start_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ci_initiator.sv
// Directed bench for ci_initiator: a GCD-style CI slave model with dead/hung modes,
// a transaction table, and hand-written back-to-back, stall, reset and TIMEOUT=2 sequences.
module tb_ci_initiator;

    localparam int T      = 16;
    localparam int M_GCD  = 0;
    localparam int M_DEAD = 1;
    localparam int M_HANG = 2;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic busy2;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ci_initiator_if bus ();
    ci_initiator_if bus2 ();

    ci_initiator #(.TIMEOUT(T), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
    );

    ci_initiator #(.TIMEOUT(2), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master),
        .busy  (busy2)
    );

    assign bus2.ci_done   = 1'b1;
    assign bus2.ci_result = 32'hDEAD_BEEF;

    // CI slave model: sees start one edge late, drops done, then one Euclid step per cycle.
    int          mode = M_GCD;
    logic        start_d;
    logic        running;
    logic [31:0] gx;
    logic [31:0] gy;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d       <= 1'b0;
            running       <= 1'b0;
            gx            <= 32'd0;
            gy            <= 32'd0;
            bus.ci_done   <= 1'b1;
            bus.ci_result <= 32'd0;
        end else begin
            start_d <= bus.ci_start;
            if (mode == M_DEAD) begin
                bus.ci_done <= 1'b1;
                running     <= 1'b0;
            end else if (start_d && !running) begin
                bus.ci_done <= 1'b0;
                running     <= 1'b1;
                gx          <= bus.ci_dataa;
                gy          <= bus.ci_datab;
            end else if (running && mode == M_GCD) begin
                if (gy != 32'd0) begin
                    gx <= gy;
                    gy <= gx % gy;
                end else begin
                    bus.ci_done   <= 1'b1;
                    bus.ci_result <= gx;
                    running       <= 1'b0;
                end
            end
        end
    end

    // Monitors: start pulses seen, and operand changes while a transaction is open.
    int          start_cnt = 0;
    int          op_bad    = 0;
    logic [31:0] cur_a     = 32'd0;
    logic [31:0] cur_b     = 32'd0;
    always @(negedge clk) begin
        if (bus.ci_start) start_cnt++;
        if (busy && (bus.ci_dataa !== cur_a || bus.ci_datab !== cur_b)) op_bad++;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int rr_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc);
        cur_a = a;
        cur_b = b;
        acc   = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (acc < 0) fail_now("req_accept");
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                at = cyc;
                break;
            end
            if (bus.req_ready) rr_bad++;
        end
        if (at < 0) fail_now("rsp_wait");
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        logic [31:0] exp_data;
        logic        exp_to;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc, acc2, at, h, s0, o0, stall_bad;

        vecs[0] = '{32'd48,         32'd18,         M_GCD,  32'd6,          1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  M_GCD,  32'hFFFF_FFFF,  1'b0};
        vecs[2] = '{32'd5,          32'd9,          M_DEAD, 32'd0,          1'b1};
        vecs[3] = '{32'd1071,       32'd462,        M_GCD,  32'd21,         1'b0};
        vecs[4] = '{32'd100,        32'd75,         M_HANG, 32'd0,          1'b1};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.rsp_ready  = 1'b0;
        bus2.req_valid = 1'b0;
        bus2.req_a     = 32'd0;
        bus2.req_b     = 32'd0;
        bus2.rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_ci_clk_en", {31'd0, bus.ci_clk_en}, 32'd0);
        check("rst_ci_start", {31'd0, bus.ci_start}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        check("rst_ci_dataa", bus.ci_dataa, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("clk_en_before_edge", {31'd0, bus.ci_clk_en}, 32'd0);
        @(posedge clk);
        #1;
        check("clk_en_after_edge", {31'd0, bus.ci_clk_en}, 32'd1);
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);

        // Transaction table
        for (int i = 0; i < 5; i++) begin
            mode   = vecs[i].mode;
            s0     = start_cnt;
            o0     = op_bad;
            rr_bad = 0;
            send(vecs[i].a, vecs[i].b, acc);
            wait_rsp(at);
            check($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].exp_data);
            check($sformatf("v%0d_rsp_timeout", i), {31'd0, bus.rsp_timeout}, {31'd0, vecs[i].exp_to});
            check($sformatf("v%0d_start_pulses", i), start_cnt - s0, 32'd1);
            check($sformatf("v%0d_operand_changes", i), op_bad - o0, 32'd0);
            check($sformatf("v%0d_req_ready_while_busy", i), rr_bad, 32'd0);
            // latency counted with the handshake cycle as cycle 0
            if (vecs[i].exp_to) check($sformatf("v%0d_abort_latency", i), at - acc + 1, T + 2);
            take_rsp();
            check($sformatf("v%0d_rsp_valid_cleared", i), {31'd0, bus.rsp_valid}, 32'd0);
        end
        mode = M_DEAD;
        repeat (2) @(posedge clk);
        mode = M_GCD;

        // Back-to-back with rsp_ready held high
        bus.rsp_ready = 1'b1;
        send(32'd0, 32'd7, acc);
        wait_rsp(at);
        check("b2b_first_data", bus.rsp_data, 32'd7);
        check("b2b_req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        h = cyc;
        send(32'd0, 32'd0, acc2);
        check("b2b_accept_gap", acc2 - h, 32'd1);
        wait_rsp(at);
        check("b2b_second_data", bus.rsp_data, 32'd0);
        check("b2b_second_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;

        // Response held off for 20 cycles
        send(32'd48, 32'd18, acc);
        wait_rsp(at);
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== 32'd6 || bus.req_ready) stall_bad++;
        end
        check("stall_hold", stall_bad, 32'd0);
        take_rsp();
        check("stall_valid_cleared", {31'd0, bus.rsp_valid}, 32'd0);
        check("stall_back_idle", {31'd0, busy}, 32'd0);
        check("stall_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("stall_data_kept", bus.rsp_data, 32'd6);

        // Reset asserted while the slave is computing
        send(32'd48, 32'd18, acc);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.ci_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("slave_done_fall");
        @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ci_clk_en", {31'd0, bus.ci_clk_en}, 32'd0);
        check("mid_rst_rsp_data", bus.rsp_data, 32'd0);
        check("mid_rst_ci_dataa", bus.ci_dataa, 32'd0);
        check("mid_rst_ci_datab", bus.ci_datab, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_clk_en_low", {31'd0, bus.ci_clk_en}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_clk_en_high", {31'd0, bus.ci_clk_en}, 32'd1);
        send(32'd1071, 32'd462, acc);
        wait_rsp(at);
        check("post_rst_data", bus.rsp_data, 32'd21);
        check("post_rst_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        take_rsp();

        // TIMEOUT=2 instance with done never falling
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_a     = 32'd3;
        bus2.req_b     = 32'd4;
        acc = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus2.req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        bus2.req_valid = 1'b0;
        if (acc < 0) fail_now("t2_accept");
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus2.rsp_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("t2_rsp_wait");
        check("t2_abort_latency", at - acc + 1, 32'd4);
        check("t2_rsp_timeout", {31'd0, bus2.rsp_timeout}, 32'd1);
        check("t2_rsp_data", bus2.rsp_data, 32'd0);
        @(posedge clk);
        #1;
        check("t2_back_idle", {31'd0, busy2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ci_initiator.md
Name: ci_initiator

Overview:
- Master end of the Nios II custom-instruction handshake (clk_en/start/dataa/datab/done/result).
- Takes operand pairs on a valid/ready request port and runs one multi-cycle custom-instruction transaction per pair against an attached CI slave.
- Returns the slave result on a valid/ready response port.
- Used to drive CI accelerators (e.g. the GCD unit) from non-CPU logic and as an in-system exerciser; includes a watchdog so a dead slave cannot hang the requester.

Parameters:
- TIMEOUT, 4096: max cycles spent in ARM+BUSY combined before the transaction is abandoned; legal range 2..65535.
- CNT_W, 16: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request operands present
- req_ready  out  1  initiator accepts a request this cycle
- req_a  in  32  operand A
- req_b  in  32  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  slave result, or 0 on timeout
- rsp_timeout  out  1  response is a watchdog abort
- busy  out  1  high in every state except IDLE
- ci_clk_en  out  1  CI clock enable to slave
- ci_start  out  1  CI start to slave
- ci_dataa  out  32  CI operand A
- ci_datab  out  32  CI operand B
- ci_done  in  1  slave done (high when the slave is idle)
- ci_result  in  32  slave result

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; ci_start=0; ci_dataa=0; ci_datab=0; rsp_valid=0; rsp_data=0; rsp_timeout=0; ci_clk_en=0; counter=0.
- ci_clk_en: registered. It goes 1 on the first clk edge after reset deasserts and stays 1.
- req_ready and busy: decoded from state. req_ready = (state==IDLE) && ci_clk_en.
- IDLE: on req_valid && req_ready, register req_a/req_b into ci_dataa/ci_datab, clear counter, go to ISSUE.
- ISSUE (1 cycle): ci_start=1 (registered, exactly one cycle wide), then go to ARM.
- ARM: wait for ci_done==0, which is the slave acknowledging start. The slave's start edge detector adds latency, so done is ignored until it has fallen. On ci_done==0, go to BUSY.
- BUSY: wait for ci_done==1. On that edge: rsp_data<=ci_result, rsp_timeout<=0, rsp_valid<=1, go to RESP.
- Watchdog:
  - Counter increments every cycle in ARM/BUSY.
  - If counter==TIMEOUT-1 and the state is not transitioning this cycle: rsp_data<=0, rsp_timeout<=1, rsp_valid<=1, go to RESP.
  - Effect: the abort response is valid exactly TIMEOUT+2 cycles after the request handshake edge.
- RESP: hold rsp_valid/rsp_data/rsp_timeout stable until rsp_ready. On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE. rsp_data keeps its last value.
- Operand stability: ci_dataa/ci_datab change only on a request accept. They are stable from ISSUE through the end of BUSY and beyond.
- Single outstanding transaction: req_ready=0 outside IDLE. The minimum gap between accepts is the transaction length plus 1 IDLE cycle. There is no same-cycle response-to-request bypass.
- rsp_ready held high: the response is still valid for at least 1 cycle.
- ci_done glitch in ISSUE: ci_done value during ISSUE is ignored.
- ci_done already low in ARM: if done is already low on the first ARM cycle (slave mid-operation), go to BUSY immediately. The result is whatever the slave produces next; this is an integration error but is not flagged.
- Operand values: zero and all-ones operands are passed unmodified. No arithmetic is done in this block.
- Reset mid-operation: every state returns to the reset values immediately and any in-flight response is lost. ci_start deasserts asynchronously.
- Watchdog boundary: TIMEOUT=2 is legal; the abort response is valid 4 cycles after accept when done never falls.

Test Plan:
- GCD slave attached, req (48,18) -> ci_start is one pulse, ci_dataa=48, ci_datab=18 held through BUSY; rsp_data=6, rsp_timeout=0; req_ready stays low until the handshake.
- req (0,7), then (0,0) back-to-back with rsp_ready=1 -> responses 7 then 0, in order; exactly one IDLE cycle between the response handshake and the next accept.
- rsp_ready held low 20 cycles after the response -> rsp_valid/rsp_data stable the whole time, req_ready=0; accept on cycle 21, then IDLE.
- No slave (ci_done tied 1), TIMEOUT=16 -> rsp_valid at accept+18 with rsp_timeout=1, rsp_data=0; the next request proceeds normally.
- Slave drops done then hangs low, TIMEOUT=16 -> BUSY aborts at the same accept+18 point with rsp_timeout=1.
- reset asserted in BUSY -> all outputs at reset values the same cycle; ci_clk_en=0 until the first edge after release; a new request then completes correctly (e.g. (1071,462) -> 21).
